// File: rtl/dcache_pkg.sv
// Shared types and defaults for the data-cache controllers.
// Used by the write-through controller and the SRAM-side controller.
package dcache_pkg;

    localparam int LEN       = 32;
    localparam int IDX_BITS  = 4;
    localparam int BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_t;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid bits, tags and one data word per line.
// Combinational indexed read, synchronous write and synchronous valid clear.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int len      = LEN,
    parameter int idx_bits = IDX_BITS,
    parameter int tag_bits = LEN - 2 - IDX_BITS
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [idx_bits-1:0] rd_idx,
    output logic                rd_valid,
    output logic [tag_bits-1:0] rd_tag,
    output logic [len-1:0]      rd_data,
    input  logic                we,
    input  logic [idx_bits-1:0] wr_idx,
    input  logic [tag_bits-1:0] wr_tag,
    input  logic [len-1:0]      wr_data
);

    localparam int LINES = 1 << idx_bits;

    logic [LINES-1:0]    valid;
    logic [tag_bits-1:0] tags [LINES];
    logic [len-1:0]      data [LINES];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents are left untouched by clear; valid gates them.
    always_ff @(posedge clk) begin
        if (we && !clr) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Hits complete combinationally; misses and all stores stall via ready.
module dcache_wt_ctrl
    import dcache_pkg::*;
#(
    parameter int          len       = LEN,
    parameter int          idx_bits  = IDX_BITS,
    parameter int unsigned base_addr = BASE_ADDR
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           MEM_R_EN,
    input  logic           MEM_W_EN,
    input  logic [len-1:0] address,
    input  logic [len-1:0] wdata,
    output logic [len-1:0] rdata,
    output logic           ready,
    output logic           mem_read,
    output logic           mem_write,
    output logic [len-1:0] mem_addr,
    output logic [len-1:0] mem_wdata,
    input  logic [len-1:0] mem_rdata,
    input  logic           mem_ready
);

    localparam int            TAG_BITS = len - 2 - idx_bits;
    localparam logic [len-1:0] BASE    = len'(base_addr);

    state_t state, state_nx;

    logic [len-1:0]      off;
    logic [len-3:0]      word;
    logic [idx_bits-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                unused_off;

    logic                line_valid;
    logic [TAG_BITS-1:0] line_tag;
    logic [len-1:0]      line_data;
    logic                hit;

    logic                fill_we;
    logic [len-1:0]      fill_data;

    assign off        = address - BASE;
    assign word       = off[len-1:2];
    assign unused_off = ^off[1:0];
    assign idx        = word[idx_bits-1:0];
    assign tag        = word[len-3:idx_bits];

    assign hit = line_valid && (line_tag == tag);

    assign mem_addr  = address;
    assign mem_wdata = wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ready     = 1'b1;
        rdata     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        fill_we   = 1'b0;
        fill_data = mem_rdata;
        unique case (state)
            IDLE: begin
                // A combined load/store request is handled as a store.
                if (MEM_W_EN) begin
                    ready    = 1'b0;
                    state_nx = WR_THRU;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        rdata = line_data;
                    end else begin
                        ready    = 1'b0;
                        state_nx = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_read = 1'b1;
                ready    = 1'b0;
                if (mem_ready) begin
                    rdata    = mem_rdata;
                    ready    = 1'b1;
                    fill_we  = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_THRU: begin
                mem_write = 1'b1;
                ready     = 1'b0;
                if (mem_ready) begin
                    ready     = 1'b1;
                    fill_we   = hit;
                    fill_data = wdata;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    dcache_array #(
        .len      (len),
        .idx_bits (idx_bits),
        .tag_bits (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .clr      (rst),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (fill_we && !rst),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (fill_data)
    );

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Directed bench for dcache_wt_ctrl with a backing-memory model.
// Expected load data is queued at issue and popped at completion.
module tb_dcache_wt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] address, wdata, rdata;
    logic        ready, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [int];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    dcache_wt_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<queued value>", tag, obs);
        end else begin
            exp = sb.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
    endtask

    // Lets any stuck transaction finish so later steps start from IDLE.
    task automatic drain();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            MEM_R_EN  = 1'b0;
            MEM_W_EN  = 1'b0;
            mem_ready = 1'b0;
            #2;
            if (!mem_read && !mem_write) return;
            mem_ready = 1'b1;
        end
        chk("drain_timeout", {30'd0, mem_read, mem_write}, 32'd0);
    endtask

    task automatic access(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit exp_hit, input int lat);
        bit is_rd;
        is_rd = r && !w;
        @(negedge clk);
        MEM_R_EN  = r;
        MEM_W_EN  = w;
        address   = a;
        wdata     = d;
        mem_ready = 1'b0;
        if (is_rd) sb.push_back(mem_model[a]);
        #2;
        if (is_rd && exp_hit) begin
            chk("hit_ready", {31'd0, ready}, 32'd1);
            chk("hit_mem_read", {31'd0, mem_read}, 32'd0);
            chk_pop("hit_rdata", rdata);
        end else begin
            chk("req_ready", {31'd0, ready}, 32'd0);
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                #2;
                chk(w ? "wr_strobe" : "rd_strobe",
                    {31'd0, w ? mem_write : mem_read}, 32'd1);
                chk(w ? "wr_no_read" : "rd_no_write",
                    {31'd0, w ? mem_read : mem_write}, 32'd0);
                chk("stall_ready", {31'd0, ready}, 32'd0);
            end
            @(negedge clk);
            mem_ready = 1'b1;
            mem_rdata = is_rd ? mem_model[a] : 32'hBAD0_BAD0;
            #2;
            chk("done_ready", {31'd0, ready}, 32'd1);
            chk("mem_addr", mem_addr, a);
            if (w) begin
                chk("mem_wdata", mem_wdata, d);
                chk("done_no_read", {31'd0, mem_read}, 32'd0);
                mem_model[a] = d;
            end else begin
                chk_pop("fill_rdata", rdata);
            end
        end
        drain();
        idle_check("after");
    endtask

    initial begin
        rst       = 1'b1;
        MEM_R_EN  = 1'b0;
        MEM_W_EN  = 1'b0;
        address   = 32'd1024;
        wdata     = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        mem_model[1024] = 32'hDEAD_BEEF;
        mem_model[1028] = 32'h0BAD_F00D;
        mem_model[1032] = 32'h0000_0000;
        mem_model[1088] = 32'h1111_1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        idle_check("reset");

        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 2);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 0);

        access(1'b0, 1'b1, 32'd1024, 32'h1234_5678, 1'b0, 2);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 0);

        access(1'b0, 1'b1, 32'd1088, 32'hA5A5_A5A5, 1'b0, 1);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 0);
        access(1'b1, 1'b0, 32'd1088, 32'd0, 1'b0, 0);

        // Reset in the middle of a read miss, then a late mem_ready.
        @(negedge clk);
        MEM_R_EN = 1'b1;
        address  = 32'd1028;
        #2;
        chk("abort_req_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("abort_mem_read", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        MEM_R_EN  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        #2;
        idle_check("abort");
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        idle_check("abort_late");
        access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 1);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 0);

        access(1'b1, 1'b1, 32'd1032, 32'hCAFE_0001, 1'b0, 2);
        access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 0);
        access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b1, 0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
